// File: rtl/stopwatch_core_if.sv
//------------------------------------------------------------------------------
// Module : stopwatch_core_if
// Brief  : Button-pulse inputs and display outputs of the stopwatch core.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface stopwatch_core_if;
    logic       one_pulse;
    logic       ten_pulse;
    logic       pause_pulse;
    logic       clear_pulse;
    logic [7:0] ssd;
    logic       running;

    modport master (
        output one_pulse, ten_pulse, pause_pulse, clear_pulse,
        input  ssd, running
    );

    modport slave (
        input  one_pulse, ten_pulse, pause_pulse, clear_pulse,
        output ssd, running
    );
endinterface

`default_nettype wire

// File: rtl/stopwatch_core.sv
//------------------------------------------------------------------------------
// Module : stopwatch_core
// Brief  : Two-digit BCD seconds counter with run/pause FSM and multiplexed
//          seven-segment output. STOPWATCH_LEADING_BLANK_EN blanks a zero tens.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module stopwatch_core #(
    parameter int TICK_DIV = 12_000_000,
    parameter int DISP_DIV = 12_000
) (
    input  wire               clk,
    input  wire               rst,
    stopwatch_core_if.slave   bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = (DISP_DIV > 1) ? $clog2(DISP_DIV) : 1;
    localparam logic [PW-1:0] c_TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] c_DISP_LAST = DW'(DISP_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [3:0]    r_ones;
    logic [3:0]    r_tens;
    logic [DW-1:0] r_dcnt;
    logic          r_sel;
    logic [7:0]    r_ssd;
    logic          r_running;

    logic          w_tick;
    logic          w_preset_ok;
    logic          w_inc_one;
    logic          w_inc_ten;
    logic          w_carry;
    logic [3:0]    w_ones_nxt;
    logic [3:0]    w_tens_sum;
    logic [3:0]    w_tens_nxt;
    state_t        w_state_nxt;
    logic [3:0]    w_disp_digit;
    logic [6:0]    w_disp_seg;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'h3F;
            4'd1:    f_seg = 7'h06;
            4'd2:    f_seg = 7'h5B;
            4'd3:    f_seg = 7'h4F;
            4'd4:    f_seg = 7'h66;
            4'd5:    f_seg = 7'h6D;
            4'd6:    f_seg = 7'h7D;
            4'd7:    f_seg = 7'h07;
            4'd8:    f_seg = 7'h7F;
            4'd9:    f_seg = 7'h6F;
            default: f_seg = 7'h00;
        endcase
    endfunction

    // A ones increment (tick or preset) is applied before the tens preset.
    always_comb begin
        w_tick      = (r_state == S_RUN) && (r_presc == c_TICK_LAST);
        w_preset_ok = (r_state != S_RUN);
        w_inc_one   = w_tick || (w_preset_ok && bus.one_pulse);
        w_inc_ten   = w_preset_ok && bus.ten_pulse;
        w_carry     = 1'b0;
        w_ones_nxt  = r_ones;
        if (w_inc_one) begin
            if (r_ones == 4'd9) begin
                w_ones_nxt = 4'd0;
                w_carry    = 1'b1;
            end else begin
                w_ones_nxt = r_ones + 4'd1;
            end
        end
        w_tens_sum = r_tens + {3'd0, w_carry} + {3'd0, w_inc_ten};
        w_tens_nxt = (w_tens_sum >= 4'd10) ? (w_tens_sum - 4'd10) : w_tens_sum;

        w_state_nxt = r_state;
        if (bus.pause_pulse) begin
            w_state_nxt = (r_state == S_RUN) ? S_PAUSED : S_RUN;
        end
    end

    always_comb begin
        w_disp_digit = r_sel ? r_tens : r_ones;
        w_disp_seg   = f_seg(w_disp_digit);
`ifdef STOPWATCH_LEADING_BLANK_EN
        if (r_sel && (r_tens == 4'd0)) begin
            w_disp_seg = 7'h00;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_ones    <= 4'd0;
            r_tens    <= 4'd0;
            r_dcnt    <= '0;
            r_sel     <= 1'b0;
            r_ssd     <= 8'h3F;
            r_running <= 1'b0;
        end else begin
            if (r_dcnt == c_DISP_LAST) begin
                r_dcnt <= '0;
                r_sel  <= ~r_sel;
            end else begin
                r_dcnt <= r_dcnt + 1'b1;
            end
            r_ssd <= {r_sel, w_disp_seg};

            if (bus.clear_pulse) begin
                r_state   <= S_IDLE;
                r_presc   <= '0;
                r_ones    <= 4'd0;
                r_tens    <= 4'd0;
                r_running <= 1'b0;
            end else begin
                if (r_state == S_RUN) begin
                    r_presc <= w_tick ? '0 : (r_presc + 1'b1);
                end
                r_ones    <= w_ones_nxt;
                r_tens    <= w_tens_nxt;
                r_state   <= w_state_nxt;
                r_running <= (w_state_nxt == S_RUN);
            end
        end
    end

    assign bus.ssd     = r_ssd;
    assign bus.running = r_running;

endmodule

`default_nettype wire
